vga_timing_gen: RTL

//  Parametrised VGA raster generator with a start-up hold-off, a framed sub-window and

---
 rtl/vga_timing_gen_if.sv | 32 +++
 rtl/vga_timing_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: mode and source data in,
// pixel fetch request out, registered sync/enable strobes and colour pins.
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic [1:0]    cmd;
  logic [11:0]   data_in;
  logic          pix_req;
  logic [CW-1:0] req_x;
  logic [CW-1:0] req_y;
  logic          hsync;
  logic          vsync;
  logic          valid;
  logic          valid_win;
  logic          frame_start;
  logic          ready;
  logic [3:0]    vga_r;
  logic [3:0]    vga_g;
  logic [3:0]    vga_b;

  modport master (
    input  cmd, data_in,
    output pix_req, req_x, req_y, hsync, vsync, valid, valid_win,
           frame_start, ready, vga_r, vga_g, vga_b
  );

  modport slave (
    output cmd, data_in,
    input  pix_req, req_x, req_y, hsync, vsync, valid, valid_win,
           frame_start, ready, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster generator: start-up hold-off, sync/active timing, a framed
// sub-window with one-cycle-ahead pixel fetch, and frame-synchronous colour
// modes (pass, grey, invert, colour bars).
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 60,
  parameter int V_ACTIVE = 350,
  parameter int V_FRONT  = 37,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int WIN_X0   = 120,
  parameter int WIN_Y0   = 25,
  parameter int WIN_W    = 400,
  parameter int WIN_H    = 300,
  parameter int STARTUP  = 1024,
  parameter int CW       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master bus
);

  localparam int HT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int VT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  // Hold-off counter is sized from STARTUP alone, independent of CW.
  localparam int SW = (STARTUP > 1) ? $clog2(STARTUP) : 1;

  localparam logic [SW-1:0] SU_LAST = SW'(STARTUP - 1);
  localparam logic [CW-1:0] H_LAST  = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(VT - 1);
  localparam logic [CW-1:0] HS_END  = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_END  = CW'(V_SYNC);
  localparam logic [CW-1:0] HA_BEG  = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] HA_END  = CW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CW-1:0] VA_BEG  = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] VA_END  = CW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [CW-1:0] HW_BEG  = CW'(H_SYNC + H_BACK + WIN_X0);
  localparam logic [CW-1:0] HW_END  = CW'(H_SYNC + H_BACK + WIN_X0 + WIN_W);
  localparam logic [CW-1:0] VW_BEG  = CW'(V_SYNC + V_BACK + WIN_Y0);
  localparam logic [CW-1:0] VW_END  = CW'(V_SYNC + V_BACK + WIN_Y0 + WIN_H);
  localparam logic [CW-1:0] BW_LAST = CW'(WIN_W / 8 - 1);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_GREY = 2'b01;
  localparam logic [1:0] MODE_INV  = 2'b10;
  localparam logic [1:0] MODE_BARS = 2'b11;

  // Luma approximation (5R+9G+2B)/16; worst case 16*15=240 fits in 8 bits.
  function automatic logic [3:0] luma(input logic [11:0] rgb);
    logic [7:0] acc;
    acc = 8'd5 * {4'd0, rgb[11:8]} + 8'd9 * {4'd0, rgb[7:4]} + 8'd2 * {4'd0, rgb[3:0]};
    return acc[7:4];
  endfunction

  // Bar index advance, saturating at the last bar so the remainder pixels
  // of a window not divisible by 8 stay on bar 7.
  function automatic logic [2:0] bar_next(input logic [2:0] idx);
    return (idx == 3'd7) ? 3'd7 : idx + 3'd1;
  endfunction

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    unique case (idx)
      3'd0: c = 12'hF00;
      3'd1: c = 12'h0F0;
      3'd2: c = 12'h00F;
      3'd3: c = 12'hF0F;
      3'd4: c = 12'hFF0;
      3'd5: c = 12'h0FF;
      3'd6: c = 12'hFFF;
      3'd7: c = 12'h000;
    endcase
    return c;
  endfunction

  logic [SW-1:0] su_cnt_q, su_cnt_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          valid_q, valid_d;
  logic          valid_win_q, valid_win_d;
  logic          frame_start_q, frame_start_d;
  logic [1:0]    mode_q, mode_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [CW-1:0] bar_px_q, bar_px_d;

  logic          h_act, v_act, h_win, v_win, in_win;
  logic [CW-1:0] win_x, win_y;
  logic [11:0]   colour;

  // Start-up hold-off, then free-running horizontal/vertical raster counters.
  always_comb begin
    su_cnt_d = su_cnt_q;
    ready_d  = ready_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    if (!ready_q) begin
      if (su_cnt_q == SU_LAST) begin
        ready_d = 1'b1;
      end else begin
        su_cnt_d = su_cnt_q + 1'b1;
      end
    end else if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end
  end

  // Active-area and window decode of the current counter state.
  always_comb begin
    h_act  = (hcnt_q >= HA_BEG) && (hcnt_q < HA_END);
    v_act  = (vcnt_q >= VA_BEG) && (vcnt_q < VA_END);
    h_win  = (hcnt_q >= HW_BEG) && (hcnt_q < HW_END);
    v_win  = (vcnt_q >= VW_BEG) && (vcnt_q < VW_END);
    in_win = ready_q && h_win && v_win;
    win_x  = hcnt_q - HW_BEG;
    win_y  = vcnt_q - VW_BEG;
  end

  // Pixel fetch goes out one cycle ahead of the matching display cycle.
  assign bus.pix_req = in_win;
  assign bus.req_x   = in_win ? win_x : '0;
  assign bus.req_y   = in_win ? win_y : '0;

  // Next values of the registered strobes; they trail the counters by one clock.
  always_comb begin
    hsync_d       = (ready_q && (hcnt_q < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = (ready_q && (vcnt_q < VS_END)) ? VS_POL : ~VS_POL;
    valid_d       = ready_q && h_act && v_act;
    valid_win_d   = in_win;
    frame_start_d = ready_q && (hcnt_q == '0) && (vcnt_q == '0);
    // Mode only changes on the frame_start clock so a frame never mixes modes.
    mode_d        = frame_start_q ? bus.cmd : mode_q;
  end

  // Bar tracking follows the request, so bar_idx_q lines up with valid_win_q.
  always_comb begin
    bar_idx_d = bar_idx_q;
    bar_px_d  = bar_px_q;
    if (in_win) begin
      if (win_x == '0) begin
        bar_idx_d = '0;
        bar_px_d  = '0;
      end else if (bar_px_q == BW_LAST) begin
        bar_idx_d = bar_next(bar_idx_q);
        bar_px_d  = '0;
      end else begin
        bar_px_d  = bar_px_q + 1'b1;
      end
    end
  end

  // State and registered outputs; reset also restarts the hold-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      su_cnt_q      <= '0;
      ready_q       <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      valid_q       <= 1'b0;
      valid_win_q   <= 1'b0;
      frame_start_q <= 1'b0;
      mode_q        <= MODE_PASS;
      bar_idx_q     <= '0;
      bar_px_q      <= '0;
    end else begin
      su_cnt_q      <= su_cnt_d;
      ready_q       <= ready_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      valid_q       <= valid_d;
      valid_win_q   <= valid_win_d;
      frame_start_q <= frame_start_d;
      mode_q        <= mode_d;
      bar_idx_q     <= bar_idx_d;
      bar_px_q      <= bar_px_d;
    end
  end

  // Colour path: combinational from source data, blanked outside the window.
  always_comb begin
    colour = 12'h000;
    if (valid_win_q) begin
      unique case (mode_q)
        MODE_PASS: colour = bus.data_in;
        MODE_GREY: colour = {3{luma(bus.data_in)}};
        MODE_INV:  colour = ~bus.data_in;
        MODE_BARS: colour = bar_colour(bar_idx_q);
      endcase
    end
  end

  assign bus.vga_r       = colour[11:8];
  assign bus.vga_g       = colour[7:4];
  assign bus.vga_b       = colour[3:0];
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.valid       = valid_q;
  assign bus.valid_win   = valid_win_q;
  assign bus.frame_start = frame_start_q;
  assign bus.ready       = ready_q;

endmodule
